// File: rtl/line_buffer_3x3.sv
// rtl/line_buffer_3x3.sv - streaming 3x3 neighbourhood generator with two line memories
module line_buffer_3x3 #(
    parameter int P_SUBPIXEL_DEPTH = 8,
    parameter int P_IMAGE_WIDTH    = 640,
    parameter int P_IMAGE_HEIGHT   = 480
) (
    input  logic                            I_CLK,
    input  logic                            I_RESET,
    input  logic [P_SUBPIXEL_DEPTH-1:0]     I_PIXEL,
    input  logic                            I_VALID,
    output logic [9*P_SUBPIXEL_DEPTH-1:0]   O_WINDOW,
    output logic                            O_VALID,
    output logic                            O_FRAME_DONE
);
    localparam int D     = P_SUBPIXEL_DEPTH;
    localparam int COL_W = $clog2(P_IMAGE_WIDTH);
    localparam int ROW_W = $clog2(P_IMAGE_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(P_IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(P_IMAGE_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [D-1:0]     line1 [P_IMAGE_WIDTH];
    logic [D-1:0]     line2 [P_IMAGE_WIDTH];
    logic [D-1:0]     win      [9];
    logic [D-1:0]     win_next [9];
    logic [9*D-1:0]   win_flat;
    logic [D-1:0]     top;
    logic [D-1:0]     mid;
    logic             col_last;
    logic             row_last;
    logic             emit;

    assign top      = line2[col];
    assign mid      = line1[col];
    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);
    // Only pixels whose whole neighbourhood is inside the current frame produce a window,
    // so stale line-memory contents from the previous frame never reach the output.
    assign emit     = I_VALID && (row >= ROW_TWO) && (col >= COL_TWO);

    always_ff @(posedge I_CLK or negedge I_RESET) begin
        if (!I_RESET) begin
            col <= '0;
            row <= '0;
        end else if (I_VALID) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Read-before-write: top/mid above see the old contents in the same cycle.
    always_ff @(posedge I_CLK) begin
        if (I_VALID) begin
            line2[col] <= line1[col];
            line1[col] <= I_PIXEL;
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_next[3*r]     = win[3*r+1];
            win_next[3*r + 1] = win[3*r+2];
            win_next[3*r + 2] = '0;
        end
        win_next[2] = top;
        win_next[5] = mid;
        win_next[8] = I_PIXEL;
    end

    always_comb begin
        win_flat = '0;
        for (int i = 0; i < 9; i++) begin
            win_flat[i*D +: D] = win_next[i];
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESET) begin
        if (!I_RESET) begin
            for (int i = 0; i < 9; i++) begin
                win[i] <= '0;
            end
            O_WINDOW     <= '0;
            O_VALID      <= 1'b0;
            O_FRAME_DONE <= 1'b0;
        end else begin
            O_VALID      <= emit;
            O_FRAME_DONE <= emit && row_last && col_last;
            if (I_VALID) begin
                for (int i = 0; i < 9; i++) begin
                    win[i] <= win_next[i];
                end
            end
            if (emit) begin
                O_WINDOW <= win_flat;
            end
        end
    end
endmodule

// File: tb/tb_line_buffer_3x3.sv
// tb/tb_line_buffer_3x3.sv - self-checking bench for line_buffer_3x3 (4x4 and 20x7 instances)
module tb_line_buffer_3x3;
    localparam int SW = 4;
    localparam int SH = 4;
    localparam int BW = 20;
    localparam int BH = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pixel = '0;
    logic        valid = 1'b0;
    logic [71:0] s_window, b_window;
    logic        s_valid, b_valid, s_done, b_done;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int stray = 0;

    logic [71:0] obs_s_win[$], obs_b_win[$], exp_s_win[$], exp_b_win[$];
    bit          obs_s_done[$], obs_b_done[$], exp_s_done[$], exp_b_done[$];
    int          obs_s_cyc[$], obs_b_cyc[$], exp_s_cyc[$], exp_b_cyc[$];

    logic [7:0] img_s [SH][SW];
    logic [7:0] img_b [BH][BW];
    int sr = 0, sc = 0, br = 0, bc = 0;

    line_buffer_3x3 #(.P_SUBPIXEL_DEPTH(8), .P_IMAGE_WIDTH(SW), .P_IMAGE_HEIGHT(SH)) dut_small (
        .I_CLK(clk), .I_RESET(rst_n), .I_PIXEL(pixel), .I_VALID(valid),
        .O_WINDOW(s_window), .O_VALID(s_valid), .O_FRAME_DONE(s_done)
    );

    line_buffer_3x3 #(.P_SUBPIXEL_DEPTH(8), .P_IMAGE_WIDTH(BW), .P_IMAGE_HEIGHT(BH)) dut_big (
        .I_CLK(clk), .I_RESET(rst_n), .I_PIXEL(pixel), .I_VALID(valid),
        .O_WINDOW(b_window), .O_VALID(b_valid), .O_FRAME_DONE(b_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (s_valid) begin
            obs_s_win.push_back(s_window);
            obs_s_done.push_back(s_done);
            obs_s_cyc.push_back(cyc);
        end
        if (b_valid) begin
            obs_b_win.push_back(b_window);
            obs_b_done.push_back(b_done);
            obs_b_cyc.push_back(cyc);
        end
        if ((s_done && !s_valid) || (b_done && !b_valid)) stray++;
    end

    // Reference: keep the whole frame as an image and cut the 3x3 neighbourhood out of it.
    task automatic model_accept(input logic [7:0] p, input int acc);
        logic [71:0] w;
        img_s[sr][sc] = p;
        if (sr >= 2 && sc >= 2) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    w[(3*i+j)*8 +: 8] = img_s[sr-2+i][sc-2+j];
            exp_s_win.push_back(w);
            exp_s_done.push_back(sr == SH-1 && sc == SW-1);
            exp_s_cyc.push_back(acc);
        end
        sc++;
        if (sc == SW) begin sc = 0; sr++; if (sr == SH) sr = 0; end
        img_b[br][bc] = p;
        if (br >= 2 && bc >= 2) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    w[(3*i+j)*8 +: 8] = img_b[br-2+i][bc-2+j];
            exp_b_win.push_back(w);
            exp_b_done.push_back(br == BH-1 && bc == BW-1);
            exp_b_cyc.push_back(acc);
        end
        bc++;
        if (bc == BW) begin bc = 0; br++; if (br == BH) br = 0; end
    endtask

    function automatic logic [71:0] win_at(input int base, input int r0, input int c0);
        logic [71:0] w;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(3*i+j)*8 +: 8] = 8'(base + 4*(r0+i) + c0 + j);
        return w;
    endfunction

    task automatic send(input logic [7:0] p, input logic v);
        pixel = p;
        valid = v;
        if (v) model_accept(p, cyc + 1);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        pixel = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sr = 0; sc = 0; br = 0; bc = 0;
        obs_s_win.delete(); obs_s_done.delete(); obs_s_cyc.delete();
        obs_b_win.delete(); obs_b_done.delete(); obs_b_cyc.delete();
        exp_s_win.delete(); exp_s_done.delete(); exp_s_cyc.delete();
        exp_b_win.delete(); exp_b_done.delete(); exp_b_cyc.delete();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pixel = 8'($urandom);
            valid = 1'b1;
            @(posedge clk);
            #1;
            n_vec++;
            if (s_valid !== 1'b0 || s_done !== 1'b0 || s_window !== '0 ||
                b_valid !== 1'b0 || b_done !== 1'b0 || b_window !== '0) begin
                n_err++;
                $display("FAIL reset_hold[%0d]: valid=%b done=%b win=%h, expected 0 0 0", k, s_valid, s_done, s_window);
            end
        end
        do_reset();
        for (int r = 0; r < SH; r++)
            for (int c = 0; c < SW; c++)
                if (!(r == SH-1 && c == SW-1)) send(8'(4*r + c), 1'b1);
        pixel = 8'd15;
        valid = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (s_valid !== 1'b1 || s_done !== 1'b1 || s_window !== win_at(0, 1, 1)) begin
            n_err++;
            $display("FAIL reset_pre: valid=%b done=%b win=%h, expected 1 1 %h", s_valid, s_done, s_window, win_at(0, 1, 1));
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (s_valid !== 1'b0 || s_done !== 1'b0 || s_window !== '0) begin
            n_err++;
            $display("FAIL reset_async: valid=%b done=%b win=%h, expected 0 0 0", s_valid, s_done, s_window);
        end
        valid = 1'b0;
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_continuous();
        do_reset();
        for (int r = 0; r < SH; r++)
            for (int c = 0; c < SW; c++)
                send(8'(4*r + c), 1'b1);
        idle(3);
        n_vec++;
        if (obs_s_win.size() != 4) begin
            n_err++;
            $display("FAIL cont_count: %0d windows, expected 4", obs_s_win.size());
        end else begin
            n_vec++;
            if (obs_s_win[0] !== win_at(0, 0, 0)) begin
                n_err++;
                $display("FAIL cont_first: got %h, expected %h", obs_s_win[0], win_at(0, 0, 0));
            end
            n_vec++;
            if (obs_s_win[3] !== win_at(0, 1, 1)) begin
                n_err++;
                $display("FAIL cont_last: got %h, expected %h", obs_s_win[3], win_at(0, 1, 1));
            end
            n_vec++;
            if ({obs_s_done[0], obs_s_done[1], obs_s_done[2], obs_s_done[3]} !== 4'b0001) begin
                n_err++;
                $display("FAIL cont_done: got %b%b%b%b, expected 0001", obs_s_done[0], obs_s_done[1], obs_s_done[2], obs_s_done[3]);
            end
        end
        for (int i = 0; i < exp_s_win.size() && i < obs_s_win.size(); i++) begin
            n_vec++;
            if (obs_s_win[i] !== exp_s_win[i] || obs_s_done[i] !== exp_s_done[i] || obs_s_cyc[i] !== exp_s_cyc[i]) begin
                n_err++;
                $display("FAIL cont_win[%0d]: got %h d=%0b cyc=%0d, expected %h d=%0b cyc=%0d", i,
                         obs_s_win[i], obs_s_done[i], obs_s_cyc[i], exp_s_win[i], exp_s_done[i], exp_s_cyc[i]);
            end
        end
    endtask

    task automatic test_gapped();
        do_reset();
        for (int r = 0; r < SH; r++)
            for (int c = 0; c < SW; c++) begin
                send(8'(4*r + c), 1'b1);
                send(8'($urandom), 1'b0);
            end
        idle(3);
        n_vec++;
        if (obs_s_win.size() != 4) begin
            n_err++;
            $display("FAIL gap_count: %0d windows, expected 4", obs_s_win.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (obs_s_win[i] !== win_at(0, i / 2, i % 2)) begin
                    n_err++;
                    $display("FAIL gap_const[%0d]: got %h, expected %h", i, obs_s_win[i], win_at(0, i / 2, i % 2));
                end
            end
        end
        for (int i = 0; i < exp_s_win.size() && i < obs_s_win.size(); i++) begin
            n_vec++;
            if (obs_s_win[i] !== exp_s_win[i] || obs_s_done[i] !== exp_s_done[i] || obs_s_cyc[i] !== exp_s_cyc[i]) begin
                n_err++;
                $display("FAIL gap_win[%0d]: got %h d=%0b cyc=%0d, expected %h d=%0b cyc=%0d", i,
                         obs_s_win[i], obs_s_done[i], obs_s_cyc[i], exp_s_win[i], exp_s_done[i], exp_s_cyc[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ndone;
        do_reset();
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < SH; r++)
                for (int c = 0; c < SW; c++)
                    send(8'(100*f + 4*r + c), 1'b1);
        idle(3);
        ndone = 0;
        foreach (obs_s_done[i]) ndone += int'(obs_s_done[i]);
        n_vec++;
        if (obs_s_win.size() != 8 || ndone != 2) begin
            n_err++;
            $display("FAIL b2b_count: %0d windows %0d done, expected 8 2", obs_s_win.size(), ndone);
        end else begin
            n_vec++;
            if (obs_s_win[4] !== win_at(100, 0, 0)) begin
                n_err++;
                $display("FAIL b2b_first2: got %h, expected %h", obs_s_win[4], win_at(100, 0, 0));
            end
            n_vec++;
            if (obs_s_cyc[4] - obs_s_cyc[3] != 2*SW + 3) begin
                n_err++;
                $display("FAIL b2b_gap: %0d cycles between frames' windows, expected %0d", obs_s_cyc[4] - obs_s_cyc[3], 2*SW + 3);
            end
        end
        for (int i = 0; i < exp_s_win.size() && i < obs_s_win.size(); i++) begin
            n_vec++;
            if (obs_s_win[i] !== exp_s_win[i] || obs_s_done[i] !== exp_s_done[i] || obs_s_cyc[i] !== exp_s_cyc[i]) begin
                n_err++;
                $display("FAIL b2b_win[%0d]: got %h d=%0b cyc=%0d, expected %h d=%0b cyc=%0d", i,
                         obs_s_win[i], obs_s_done[i], obs_s_cyc[i], exp_s_win[i], exp_s_done[i], exp_s_cyc[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int ndone;
        do_reset();
        for (int k = 0; k < 7; k++) send(8'($urandom), 1'b1);
        do_reset();
        for (int r = 0; r < SH; r++)
            for (int c = 0; c < SW; c++)
                send(8'(4*r + c), 1'b1);
        idle(3);
        ndone = 0;
        foreach (obs_s_done[i]) ndone += int'(obs_s_done[i]);
        n_vec++;
        if (obs_s_win.size() != 4 || ndone != 1) begin
            n_err++;
            $display("FAIL midrst_count: %0d windows %0d done, expected 4 1", obs_s_win.size(), ndone);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (obs_s_win[i] !== win_at(0, i / 2, i % 2)) begin
                    n_err++;
                    $display("FAIL midrst_win[%0d]: got %h, expected %h", i, obs_s_win[i], win_at(0, i / 2, i % 2));
                end
            end
        end
    endtask

    task automatic test_random();
        int acc;
        int ndone;
        logic [7:0] p;
        do_reset();
        acc = 0;
        while (acc < 3*BW*BH) begin
            case ($urandom % 8)
                0:       p = 8'h00;
                1:       p = 8'hFF;
                default: p = 8'($urandom);
            endcase
            if ($urandom % 10 < 7) begin
                send(p, 1'b1);
                acc++;
            end else begin
                send(p, 1'b0);
            end
        end
        idle(3);
        ndone = 0;
        foreach (obs_b_done[i]) ndone += int'(obs_b_done[i]);
        n_vec++;
        if (obs_b_win.size() != 3*(BH-2)*(BW-2) || ndone != 3) begin
            n_err++;
            $display("FAIL rand_count: %0d windows %0d done, expected %0d 3", obs_b_win.size(), ndone, 3*(BH-2)*(BW-2));
        end
        n_vec++;
        if (stray != 0) begin
            n_err++;
            $display("FAIL rand_stray_done: %0d frame_done pulses without valid, expected 0", stray);
        end
        for (int i = 0; i < exp_b_win.size() && i < obs_b_win.size(); i++) begin
            n_vec++;
            if (obs_b_win[i] !== exp_b_win[i] || obs_b_done[i] !== exp_b_done[i] || obs_b_cyc[i] !== exp_b_cyc[i]) begin
                n_err++;
                $display("FAIL rand_big[%0d]: got %h d=%0b cyc=%0d, expected %h d=%0b cyc=%0d", i,
                         obs_b_win[i], obs_b_done[i], obs_b_cyc[i], exp_b_win[i], exp_b_done[i], exp_b_cyc[i]);
            end
        end
        n_vec++;
        if (obs_s_win.size() != exp_s_win.size()) begin
            n_err++;
            $display("FAIL rand_small_count: %0d windows, expected %0d", obs_s_win.size(), exp_s_win.size());
        end
        for (int i = 0; i < exp_s_win.size() && i < obs_s_win.size(); i++) begin
            n_vec++;
            if (obs_s_win[i] !== exp_s_win[i] || obs_s_done[i] !== exp_s_done[i] || obs_s_cyc[i] !== exp_s_cyc[i]) begin
                n_err++;
                $display("FAIL rand_small[%0d]: got %h d=%0b cyc=%0d, expected %h d=%0b cyc=%0d", i,
                         obs_s_win[i], obs_s_done[i], obs_s_cyc[i], exp_s_win[i], exp_s_done[i], exp_s_cyc[i]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_continuous();
        test_gapped();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
